// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end.
// Holds the prefetch queue entry and PC helpers.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int PREFETCH_DEPTH = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } pf_entry_t;

  function automatic logic [XLEN-1:0] pc_next(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction memory request/response bus.
// master = prefetcher, slave = memory.
interface instr_prefetch_if;
  import riscv_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding fetched {instr, pc} entries.
// Pointers wrap naturally at the power-of-two depth.
module prefetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  pf_entry_t                i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output pf_entry_t                o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pf_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // pointer and occupancy update; flush empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: credit-limited fetch into a queue.
// Redirect flushes the queue and discards in-flight responses.
module instr_prefetch #(
  parameter int DEPTH = riscv_pkg::PREFETCH_DEPTH,
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC =
    riscv_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
  input  logic                       stall,
  output logic                       instr_valid,
  output logic [riscv_pkg::XLEN-1:0] instr,
  output logic [riscv_pkg::XLEN-1:0] instr_pc,
  output logic [riscv_pkg::XLEN-1:0] instr_pcplus4,
  instr_prefetch_if.master           imem
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_disc;
  logic [CW-1:0]   w_cnt;
  logic [CW-1:0]   w_inflight;
  logic            w_full;
  logic            w_empty;
  logic            w_credit;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  pf_entry_t       w_din;
  pf_entry_t       w_head;

  // queued plus in-flight may never exceed the queue size
  assign w_credit = (SW'(w_cnt) + SW'(r_out)) < SW'(DEPTH);

  assign imem.req  = !rst && !redirect && w_credit;
  assign imem.addr = r_fetch_pc & ~XLEN'(3);

  assign w_grant    = imem.req && imem.gnt;
  assign w_inflight = r_out + CW'(w_grant) - CW'(imem.rvalid);

  assign w_push = imem.rvalid && !redirect &&
                  (r_disc == '0) && !w_full;
  assign w_pop  = !w_empty && !stall && !redirect;
  assign w_din  = '{instr: imem.rdata, pc: r_resp_pc};

  assign instr_valid   = !w_empty;
  assign instr         = w_empty ? '0 : w_head.instr;
  assign instr_pc      = w_empty ? '0 : w_head.pc;
  assign instr_pcplus4 = w_empty ? '0 : pc_next(w_head.pc);

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // fetch/response PCs, in-flight count and stale-response discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
    end else begin
      r_out <= w_inflight;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_disc     <= w_inflight;
      end else begin
        if (w_grant) r_fetch_pc <= pc_next(r_fetch_pc);
        if (imem.rvalid) begin
          if (r_disc != '0) r_disc <= r_disc - 1'b1;
          else r_resp_pc <= pc_next(r_resp_pc);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Random bench for instr_prefetch with an epoch-tagged memory
// model and an expected-instruction queue as reference.
module tb_instr_prefetch;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  instr_prefetch_if imem();

  instr_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pcplus4 (instr_pcplus4),
    .imem          (imem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] mfetch;
  int          epoch;
  int          cyc;
  int          checks;
  int          errors;

  int          p_gnt;
  int          lat_max;
  int          p_stall;
  int          p_redir;
  logic        force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic exp_req;
    logic grant;
    logic rv;
    req_t head;
    int   d;
    @(negedge clk);
    chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("pc", instr_pc, mq[0]);
      chk("instr", instr, memword(mq[0]));
      chk("pcplus4", instr_pcplus4, mq[0] + 32'd4);
    end
    stall = ($urandom_range(99) < 32'(p_stall));
    redirect = force_redir ||
               ($urandom_range(999) < 32'(p_redir));
    if (force_redir) redirect_pc = force_pc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF4;
    else redirect_pc = $urandom & 32'h0000_FFFC;
    force_redir = 1'b0;
    imem.gnt = ($urandom_range(99) < 32'(p_gnt));
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem.rvalid = rv;
    imem.rdata = rv ? memword(pend[0].addr) : $urandom;
    #1;
    exp_req = !redirect && (mq.size() + pend.size() < DEPTH);
    chk("req", 32'(imem.req), 32'(exp_req));
    if (exp_req) chk("addr", imem.addr, mfetch);
    grant = exp_req && imem.gnt;
    @(posedge clk);
    head = '{addr: 32'h0, epoch: -1, due: 0};
    if (rv) head = pend.pop_front();
    if (grant) begin
      d = int'($urandom_range(0, lat_max));
      pend.push_back('{addr: mfetch, epoch: epoch, due: cyc + 1 + d});
      mfetch = mfetch + 32'd4;
    end
    if (redirect) begin
      mq.delete();
      epoch++;
      mfetch = redirect_pc;
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (rv && head.epoch == epoch) mq.push_back(head.addr);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_req"}, 32'(imem.req), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"}, instr_pc, 32'd0);
    chk({tag, "_pc4"}, instr_pcplus4, 32'd0);
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    mq.delete();
    pend.delete();
    epoch++;
    mfetch = RPC;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    epoch = 0;
    cyc = 0;
    mfetch = RPC;
    force_redir = 1'b0;
    force_pc = '0;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;

    reset_now("rst0");

    p_gnt = 100; lat_max = 0; p_stall = 0; p_redir = 0;
    run(30);

    p_stall = 100;
    run(12);
    p_stall = 0;
    run(10);

    force_redir = 1'b1; force_pc = 32'h0000_0100;
    run(10);

    p_stall = 100; lat_max = 2;
    run(4);
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    run(1);
    p_stall = 0;
    run(15);

    lat_max = 0;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    run(12);

    p_gnt = 60; lat_max = 3; p_stall = 30; p_redir = 25;
    run(1500);

    p_gnt = 100; lat_max = 1; p_stall = 100; p_redir = 0;
    run(4);
    reset_now("rstmid");

    p_gnt = 70; lat_max = 3; p_stall = 25; p_redir = 20;
    run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
